// File: rtl/exp_pkg.sv
// Shared constants, accumulator-width helper and coefficient bundle for the
// integer exp() pipeline.
package exp_pkg;

  localparam int EXP_LAT = 6;
  localparam int EXP_D_W = 32;

  function automatic int acc_w(input int d_w);
    return 2 * d_w + 2;
  endfunction

  typedef struct packed {
    logic signed [EXP_D_W-1:0] qb;
    logic signed [EXP_D_W-1:0] qc;
    logic signed [EXP_D_W-1:0] qln2;
    logic signed [EXP_D_W-1:0] qln2_inv;
  } exp_coef_t;

endpackage

// File: rtl/exp_lane.sv
// One lane of the integer exp() datapath: six adv-enabled register stages,
// with shift clamping and output saturation in the last stage.
module exp_lane #(
  parameter int D_W     = 32,
  parameter int FP_BITS = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic signed [D_W-1:0] qb_i,
  input  logic signed [D_W-1:0] qc_i,
  input  logic signed [D_W-1:0] qln2_i,
  input  logic signed [D_W-1:0] qln2_inv_i,
  input  logic signed [D_W-1:0] qin_i,
  output logic signed [D_W-1:0] qout_o,
  output logic                  sat_o
);
  import exp_pkg::*;

  localparam int ACC_W = acc_w(D_W);
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t OUT_MAX = {{(ACC_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
  localparam acc_t OUT_MIN = {{(ACC_W-D_W+1){1'b1}}, {(D_W-1){1'b0}}};

  function automatic acc_t sx(input logic signed [D_W-1:0] v);
    return acc_t'(v);
  endfunction

  logic signed [D_W-1:0] qin1_q, qin2_q, qin3_q;
  acc_t p1_q, z2_q, z3_q, z4_q, z5_q, m3_q, qp4_q, t5_q;
  acc_t p1_d, z2_d, m3_d, qp4_d, t5_d;
  acc_t ql, shifted;
  logic signed [D_W-1:0] qout_d, qout_q;
  logic sat_d, sat_q;

  always_comb begin
    p1_d  = sx(qin_i) * sx(qln2_inv_i);
    z2_d  = p1_q >>> FP_BITS;
    m3_d  = sx(qln2_i) * z2_q;
    qp4_d = sx(qin3_q) - m3_q;
    t5_d  = (qp4_q + sx(qb_i)) * qp4_q;
    ql    = t5_q + sx(qc_i);
    sat_d = 1'b0;
    // Negative z keeps ql unshifted; a shift of ACC_W or more flushes to zero.
    if (z5_q[ACC_W-1]) begin
      shifted = ql;
      sat_d   = 1'b1;
    end else if (z5_q >= acc_t'(ACC_W)) begin
      shifted = '0;
      sat_d   = 1'b1;
    end else begin
      shifted = ql >>> z5_q;
    end
    if (shifted > OUT_MAX) begin
      qout_d = {1'b0, {(D_W-1){1'b1}}};
      sat_d  = 1'b1;
    end else if (shifted < OUT_MIN) begin
      qout_d = {1'b1, {(D_W-1){1'b0}}};
      sat_d  = 1'b1;
    end else begin
      qout_d = shifted[D_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      qin1_q <= '0;
      qin2_q <= '0;
      qin3_q <= '0;
      p1_q   <= '0;
      z2_q   <= '0;
      z3_q   <= '0;
      z4_q   <= '0;
      z5_q   <= '0;
      m3_q   <= '0;
      qp4_q  <= '0;
      t5_q   <= '0;
      qout_q <= '0;
      sat_q  <= 1'b0;
    end else if (adv) begin
      qin1_q <= qin_i;
      p1_q   <= p1_d;
      qin2_q <= qin1_q;
      z2_q   <= z2_d;
      qin3_q <= qin2_q;
      z3_q   <= z2_q;
      m3_q   <= m3_d;
      z4_q   <= z3_q;
      qp4_q  <= qp4_d;
      z5_q   <= z4_q;
      t5_q   <= t5_d;
      qout_q <= qout_d;
      sat_q  <= sat_d;
    end
  end

  assign qout_o = qout_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/exp_multilane.sv
// Multi-lane integer exp() with valid/ready stall, guarded coefficient load,
// tag sideband and per-lane clamp flags.
module exp_multilane #(
  parameter int D_W     = 32,
  parameter int FP_BITS = 30,
  parameter int N_LANES = 4,
  parameter int TAG_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_load,
  input  logic [D_W-1:0]         cfg_qb,
  input  logic [D_W-1:0]         cfg_qc,
  input  logic [D_W-1:0]         cfg_qln2,
  input  logic [D_W-1:0]         cfg_qln2_inv,
  output logic                   cfg_ready,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_LANES*D_W-1:0] in_data,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_LANES*D_W-1:0] out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic [N_LANES-1:0]     out_sat
);
  import exp_pkg::*;

  localparam int OCC_W = $clog2(EXP_LAT + 1);

  exp_coef_t                       coef_q;
  logic [EXP_LAT-1:0]              vld_q;
  logic [EXP_LAT-1:0][TAG_W-1:0]   tag_q;
  logic [OCC_W-1:0]                occ_q, occ_d;
  logic adv, cfg_load_eff, in_acc, out_acc;

  assign out_valid    = vld_q[EXP_LAT-1];
  assign out_tag      = tag_q[EXP_LAT-1];
  assign adv          = !out_valid || out_ready;
  assign cfg_ready    = (occ_q == '0);
  assign cfg_load_eff = cfg_load && cfg_ready;
  assign in_ready     = adv && !cfg_load_eff;
  assign in_acc       = in_valid && in_ready;
  assign out_acc      = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    unique case ({in_acc, out_acc})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      coef_q <= '0;
      vld_q  <= '0;
      tag_q  <= '0;
      occ_q  <= '0;
    end else begin
      if (cfg_load_eff) begin
        coef_q <= '{qb: cfg_qb, qc: cfg_qc, qln2: cfg_qln2, qln2_inv: cfg_qln2_inv};
      end
      if (adv) begin
        vld_q <= {vld_q[EXP_LAT-2:0], in_acc};
        tag_q <= {tag_q[EXP_LAT-2:0], in_tag};
      end
      occ_q <= occ_d;
    end
  end

  // Coefficients only change while the pipe is empty, so lanes read them live.
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    exp_lane #(
      .D_W    (D_W),
      .FP_BITS(FP_BITS)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv),
      .qb_i      (coef_q.qb),
      .qc_i      (coef_q.qc),
      .qln2_i    (coef_q.qln2),
      .qln2_inv_i(coef_q.qln2_inv),
      .qin_i     (in_data[i*D_W +: D_W]),
      .qout_o    (out_data[i*D_W +: D_W]),
      .sat_o     (out_sat[i])
    );
  end

endmodule

// File: tb/tb_exp_multilane.sv
// Directed and randomized checks of exp_multilane against a spec-level model
// and an in-order scoreboard.
module tb_exp_multilane;

  typedef logic signed [65:0] a_t;
  typedef struct { int qb; int qc; int ln2; int inv; } coef_t;
  typedef struct { logic [127:0] data; logic [7:0] tag; logic [3:0] sat; int acc_cyc; } ent_t;

  localparam a_t AMAX = 66'sd2147483647;
  localparam a_t AMIN = -66'sd2147483648;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_load = 1'b0;
  logic [31:0]  cfg_qb = '0, cfg_qc = '0, cfg_qln2 = '0, cfg_qln2_inv = '0;
  logic         cfg_ready;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [7:0]   in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [7:0]   out_tag;
  logic [3:0]   out_sat;

  exp_multilane #(.D_W(32), .FP_BITS(30), .N_LANES(4), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_qb(cfg_qb), .cfg_qc(cfg_qc),
    .cfg_qln2(cfg_qln2), .cfg_qln2_inv(cfg_qln2_inv), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_cmp = 0, n_bad = 0, cyc = 0;
  ent_t sb[$];
  coef_t mc = '{0, 0, 0, 0};
  bit last_acc = 0, lat_chk = 0, hold_chk = 0;
  logic [127:0] h_data;
  logic [7:0] h_tag;
  logic [3:0] h_sat;
  bit ovr_en = 0;
  logic [127:0] ovr_data;
  logic [3:0] ovr_sat;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // exp() straight from the defining formulas, 66-bit wrapping arithmetic.
  function automatic void ref_lane(input int qin, input coef_t c, output logic [31:0] q, output logic s);
    a_t z, qp, ql, r;
    z  = (a_t'(qin) * a_t'(c.inv)) >>> 30;
    qp = a_t'(qin) - a_t'(c.ln2) * z;
    ql = (qp + a_t'(c.qb)) * qp + a_t'(c.qc);
    s  = 1'b0;
    if (z < 0) begin r = ql; s = 1'b1; end
    else if (z >= 66) begin r = '0; s = 1'b1; end
    else r = ql >>> z;
    if (r > AMAX) begin q = 32'h7fff_ffff; s = 1'b1; end
    else if (r < AMIN) begin q = 32'h8000_0000; s = 1'b1; end
    else q = r[31:0];
  endfunction

  task automatic cycle();
    ent_t e;
    bit cfg_acc, acc_out;
    logic [31:0] q;
    logic s;
    #1;
    last_acc = 0;
    if (rst) begin
      if (hold_chk) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, h_data);
        chk("hold_tag", out_tag, h_tag);
        chk("hold_sat", out_sat, h_sat);
      end
      cfg_acc = cfg_load && (sb.size() == 0);
      chk("cfg_ready", cfg_ready, sb.size() == 0);
      chk("in_ready", in_ready, (!out_valid || out_ready) && !cfg_acc);
      if (sb.size() == 0) chk("idle_valid", out_valid, 1'b0);
      acc_out = out_valid && out_ready;
      if (acc_out && sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_tag", out_tag, e.tag);
        chk("out_sat", out_sat, e.sat);
        if (lat_chk) chk("latency", cyc - e.acc_cyc, 6);
      end
      hold_chk = out_valid && !out_ready;
      h_data = out_data; h_tag = out_tag; h_sat = out_sat;
      if (in_valid && in_ready) begin
        last_acc = 1;
        e.tag = in_tag;
        e.acc_cyc = cyc;
        if (ovr_en) begin
          e.data = ovr_data; e.sat = ovr_sat; ovr_en = 0;
        end else begin
          for (int l = 0; l < 4; l++) begin
            ref_lane(in_data[l*32 +: 32], mc, q, s);
            e.data[l*32 +: 32] = q;
            e.sat[l] = s;
          end
        end
        sb.push_back(e);
      end
      if (cfg_acc) mc = '{int'(cfg_qb), int'(cfg_qc), int'(cfg_qln2), int'(cfg_qln2_inv)};
    end
    @(posedge clk);
    if (!rst) begin
      sb.delete();
      mc = '{0, 0, 0, 0};
      hold_chk = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic load(input int qb, input int qc, input int ln2, input int inv);
    cfg_qb = qb; cfg_qc = qc; cfg_qln2 = ln2; cfg_qln2_inv = inv;
    cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic [7:0] t);
    int k = 0;
    in_data = d; in_tag = t; in_valid = 1'b1;
    do begin cycle(); k++; end while (!last_acc && k < 50);
    in_valid = 1'b0;
    chk("send_accept", last_acc, 1'b1);
  endtask

  task automatic expect_next(input logic [127:0] d, input logic [3:0] s);
    ovr_en = 1; ovr_data = d; ovr_sat = s;
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    while (sb.size() > 0 && k < 100) begin cycle(); k++; end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [3:0] pat;
    int i, k;

    cycle(); cycle();
    rst = 1'b1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_tag", out_tag, '0);
    chk("rst_out_sat", out_sat, '0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b1);

    load(1, 100, 2, 1 << 29);

    // Basic beat with latency check
    lat_chk = 1;
    expect_next({4{32'd12}}, 4'b0000);
    send({4{32'd7}}, 8'h5A);
    drain();
    lat_chk = 0;

    // Mixed lanes: {7,-7,200,0}
    expect_next({32'd100, 32'd0, 32'd102, 32'd12}, 4'b0110);
    send({32'd0, 32'd200, 32'hFFFF_FFF9, 32'd7}, 8'h11);
    drain();

    // Backpressure stream with out_ready pattern 1,0,0,1
    pat = 4'b1001;
    i = 0; k = 0;
    while ((i < 20 || sb.size() > 0) && k < 400) begin
      out_ready = pat[k % 4];
      in_valid  = (i < 20);
      in_data   = {$urandom, $urandom, $urandom, 32'(i)};
      in_tag    = 8'(i);
      cycle();
      if (last_acc) i++;
      k++;
    end
    in_valid = 1'b0;
    chk("bp_sent", i, 20);
    chk("bp_drained", sb.size(), 0);
    out_ready = 1'b1;

    // Config handshake: load while busy is ignored
    expect_next({4{32'd12}}, 4'b0000);
    send({4{32'd7}}, 8'h21);
    load(1, 4, 2, 1 << 29);
    drain();
    cfg_qc = 4; cfg_load = 1'b1;
    in_data = {4{32'd7}}; in_tag = 8'h22; in_valid = 1'b1;
    expect_next({4{32'd0}}, 4'b0000);
    cycle();
    cfg_load = 1'b0;
    send({4{32'd7}}, 8'h22);
    drain();

    // Reset with four beats in flight
    load(1, 100, 2, 1 << 29);
    for (int b = 0; b < 4; b++) send({$urandom, $urandom, $urandom, $urandom}, 8'(8'h30 + b));
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_data", out_data, '0);
    chk("mid_rst_cfg_ready", cfg_ready, 1'b1);
    repeat (10) cycle();

    // Saturation
    load(0, 0, 0, 0);
    expect_next({4{32'h7fff_ffff}}, 4'b1111);
    send({4{32'h7fff_ffff}}, 8'h40);
    drain();

    // Randomized traffic, spec coefficients then a random coefficient set
    for (int r = 0; r < 2; r++) begin
      if (r == 0) load(1, 100, 2, 1 << 29);
      else load($urandom_range(0, 200), $urandom_range(0, 1000), $urandom_range(1, 4),
                $urandom_range(1 << 28, 1 << 30));
      for (int c = 0; c < 80; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        in_data   = {$urandom, 32'($urandom_range(0, 400)), 32'(int'($urandom_range(0, 4000)) - 2000), $urandom};
        in_tag    = 8'($urandom);
        cycle();
      end
      in_valid = 1'b0;
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
